// File: rtl/dual_grant_scheduler_pkg.sv
// Shared types and constants for the dual-grant request scheduler.
// The popcount helper sizes the coalesce increment for one cycle of requests.
package dual_grant_pkg;

    localparam int N_REQ = 12;
    localparam int IDX_W = 4;
    localparam int CNT_W = 8;

    typedef logic [N_REQ-1:0] req_vec_t;

    typedef struct packed {
        logic [IDX_W-1:0] first;
        logic [IDX_W-1:0] second;
        logic             second_vld;
    } grant_pair_t;

    typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_t;

    function automatic logic [IDX_W:0] popcount(req_vec_t v);
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < N_REQ; i++) n = n + (IDX_W+1)'(v[i]);
        return n;
    endfunction

endpackage

// File: rtl/dual_grant_scheduler_top2_select.sv
// Combinational search for the two highest-index set bits of a request vector.
// Returns the index pair plus a one-hot-or-two-hot mask of the bits chosen.
module top2_select
    import dual_grant_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    output grant_pair_t      pair,
    output logic             any_vld,
    output logic [N_REQ-1:0] mask
);

    always_comb begin
        pair    = '0;
        any_vld = 1'b0;
        mask    = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                if (!any_vld) begin
                    pair.first = IDX_W'(i);
                    any_vld    = 1'b1;
                    mask[i]    = 1'b1;
                end else if (!pair.second_vld) begin
                    pair.second     = IDX_W'(i);
                    pair.second_vld = 1'b1;
                    mask[i]         = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dual_grant_scheduler.sv
// Sticky request collector that issues the two highest pending sources per
// cycle over valid/ready, and counts requests that coalesce onto pending bits.
module dual_grant_scheduler
    import dual_grant_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_set,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [IDX_W-1:0]    out_first,
    output logic [IDX_W-1:0]    out_second,
    output logic                out_second_vld,
    output logic [N_REQ-1:0]    pending,
    output logic [CNT_W-1:0]    coalesce_cnt
);

    out_state_t       state, state_next;
    grant_pair_t      out_pair;
    grant_pair_t      sel_pair;
    logic             sel_any;
    logic [N_REQ-1:0] sel_mask;
    logic             load;
    logic [N_REQ-1:0] grant_mask;
    logic [CNT_W:0]   cnt_sum;
    logic [CNT_W-1:0] cnt_next;

    // Selection looks only at the registered vector, never at this cycle's req_set.
    top2_select u_sel (
        .req     (pending),
        .pair    (sel_pair),
        .any_vld (sel_any),
        .mask    (sel_mask)
    );

    assign load       = (state == OUT_EMPTY || out_ready) && sel_any && !flush;
    assign grant_mask = load ? sel_mask : '0;

    always_comb begin
        state_next = state;
        if (flush)
            state_next = OUT_EMPTY;
        else if (load)
            state_next = OUT_FULL;
        else if (state == OUT_FULL && out_ready)
            state_next = OUT_EMPTY;
    end

    assign cnt_sum  = {1'b0, coalesce_cnt}
                    + (CNT_W+1)'(popcount(req_set & pending & ~grant_mask));
    assign cnt_next = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= OUT_EMPTY;
            pending      <= '0;
            out_pair     <= '0;
            coalesce_cnt <= '0;
        end else begin
            state        <= state_next;
            coalesce_cnt <= cnt_next;
            // A request landing on a bit granted this cycle re-arms it.
            pending      <= flush ? req_set : ((pending & ~grant_mask) | req_set);
            if (load)
                out_pair <= sel_pair;
            else if (flush || (state == OUT_FULL && out_ready))
                out_pair <= '0;
        end
    end

    assign out_valid      = (state == OUT_FULL);
    assign out_first      = out_pair.first;
    assign out_second     = out_pair.second;
    assign out_second_vld = out_pair.second_vld;

endmodule

// File: tb/tb_dual_grant_scheduler.sv
// Randomised and directed check of dual_grant_scheduler against an
// index-list reference model of pending requests and the output slot.
module tb_dual_grant_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [11:0] req_set = '0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [3:0]  out_first, out_second;
    logic        out_second_vld;
    logic [11:0] pending;
    logic [7:0]  coalesce_cnt;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    bit [11:0] m_pend;
    bit        m_full;
    int        m_first, m_second;
    bit        m_svld;
    int        m_cnt;

    always #5 clk = ~clk;

    dual_grant_scheduler dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_set        (req_set),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_first      (out_first),
        .out_second     (out_second),
        .out_second_vld (out_second_vld),
        .pending        (pending),
        .coalesce_cnt   (coalesce_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend = '0; m_full = 0; m_first = 0; m_second = 0; m_svld = 0; m_cnt = 0;
    endtask

    task automatic model_tick();
        int idx[$];
        bit [11:0] gm;
        bit        ld;
        gm = '0;
        for (int i = 11; i >= 0; i--) if (m_pend[i]) idx.push_back(i);
        ld = (!m_full || out_ready) && (idx.size() > 0) && !flush;
        if (ld) begin
            m_first = idx[0];
            gm[idx[0]] = 1'b1;
            if (idx.size() > 1) begin
                m_second = idx[1]; m_svld = 1; gm[idx[1]] = 1'b1;
            end else begin
                m_second = 0; m_svld = 0;
            end
            m_full = 1;
        end else if (flush) begin
            m_full = 0; m_svld = 0;
        end else if (m_full && out_ready) begin
            m_full = 0;
        end
        m_cnt = m_cnt + $countones(req_set & m_pend & ~gm);
        if (m_cnt > 255) m_cnt = 255;
        m_pend = flush ? req_set : ((m_pend & ~gm) | req_set);
    endtask

    task automatic compare_model();
        chk("valid", int'(out_valid), int'(m_full));
        chk("pending", int'(pending), int'(m_pend));
        chk("coalesce_cnt", int'(coalesce_cnt), m_cnt);
        if (m_full) begin
            chk("first", int'(out_first), m_first);
            chk("second_vld", int'(out_second_vld), int'(m_svld));
            chk("second", int'(out_second), m_second);
        end
    endtask

    // One clock: model advances with the inputs seen at the edge, outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        model_tick();
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [11:0] r, input logic rdy, input logic fl);
        req_set = r; out_ready = rdy; flush = fl;
    endtask

    initial begin
        model_reset();
        #12;
        chk("reset_valid", int'(out_valid), 0);
        chk("reset_first", int'(out_first), 0);
        chk("reset_second_vld", int'(out_second_vld), 0);
        chk("reset_cnt", int'(coalesce_cnt), 0);
        rst_n = 1'b1;

        // idle
        drive(12'h000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", int'(out_valid), 0);
            chk("idle_pending", int'(pending), 0);
        end

        // single pulse: valid two edges later
        drive(12'h008, 1'b1, 1'b0);
        step();
        chk("lat1_valid", int'(out_valid), 0);
        drive(12'h000, 1'b1, 1'b0);
        step();
        chk("lat2_valid", int'(out_valid), 1);
        chk("lat2_first", int'(out_first), 3);
        chk("lat2_svld", int'(out_second_vld), 0);
        chk("lat2_pending", int'(pending), 0);
        step();

        // 8A1 -> (11,7), (5,0), empty
        drive(12'h8A1, 1'b1, 1'b0);
        step();
        drive(12'h000, 1'b1, 1'b0);
        step();
        chk("p1_first", int'(out_first), 11);
        chk("p1_second", int'(out_second), 7);
        chk("p1_svld", int'(out_second_vld), 1);
        step();
        chk("p2_first", int'(out_first), 5);
        chk("p2_second", int'(out_second), 0);
        chk("p2_svld", int'(out_second_vld), 1);
        step();
        chk("p3_valid", int'(out_valid), 0);

        // backpressure: (5,4) held, bit 4 re-armed without coalescing
        drive(12'h030, 1'b0, 1'b0);
        step();
        drive(12'h000, 1'b0, 1'b0);
        step();
        chk("bp_first", int'(out_first), 5);
        chk("bp_second", int'(out_second), 4);
        drive(12'h010, 1'b0, 1'b0);
        step();
        drive(12'h000, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_first", int'(out_first), 5);
            chk("bp_hold_second", int'(out_second), 4);
            chk("bp_hold_valid", int'(out_valid), 1);
        end
        chk("bp_cnt", int'(coalesce_cnt), 0);
        chk("bp_pending", int'(pending), 12'h010);
        drive(12'h000, 1'b1, 1'b0);
        step();
        chk("bp_rel_first", int'(out_first), 4);
        chk("bp_rel_svld", int'(out_second_vld), 0);

        // saturation
        drive(12'hFFF, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) step();
        chk("sat_cnt", int'(coalesce_cnt), 255);

        // flush while a pair is held
        drive(12'h002, 1'b0, 1'b1);
        step();
        chk("flush_valid", int'(out_valid), 0);
        chk("flush_pending", int'(pending), 12'h002);
        chk("flush_cnt", int'(coalesce_cnt), 255);
        drive(12'h000, 1'b1, 1'b0);
        step();
        chk("flush_next_valid", int'(out_valid), 1);
        chk("flush_next_first", int'(out_first), 1);

        // reset the counter, then randomised traffic
        #2 rst_n = 1'b0;
        #1 model_reset();
        compare_model();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 600; i++) begin
            logic [11:0] r;
            r = 12'($urandom) & 12'($urandom) & 12'($urandom);
            drive(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
            step();
        end

        // reset mid-transfer: immediate clear, no reissue
        drive(12'hC00, 1'b0, 1'b0);
        step();
        drive(12'h000, 1'b0, 1'b0);
        step();
        chk("mid_valid_before", int'(out_valid), 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid", int'(out_valid), 0);
        chk("mid_rst_first", int'(out_first), 0);
        chk("mid_rst_second", int'(out_second), 0);
        chk("mid_rst_svld", int'(out_second_vld), 0);
        chk("mid_rst_pending", int'(pending), 0);
        #2 rst_n = 1'b1;
        drive(12'h000, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("no_reissue", int'(out_valid), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
